// File: rtl/nx_ctrl_fabric_pkg.sv
// ----------------------------------------------------------------------------
// nx_ctrl_fabric_pkg
// Shared types for the multi-instance control fabric.
//   fabric_state_t : outbound merge FSM state
//     ARB    - choosing the next response source round-robin
//     LOCKED - forwarding the rest of a multi-beat packet from one channel
// ----------------------------------------------------------------------------
package nx_ctrl_fabric_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } fabric_state_t;

endpackage

// File: rtl/nx_rr_arbiter.sv
// ----------------------------------------------------------------------------
// nx_rr_arbiter
// Round-robin selector. It picks the first set request at or above an
// internal rotating pointer, wrapping modulo N. The pointer moves to
// winner+1 when 'advance' is strobed.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointer -> 0)
//   req         : request vector
//   advance     : move the pointer past the current winner
//   win_idx     : winner index (0 when no request)
//   win_onehot  : winner as a one-hot vector (0 when no request)
//   win_valid   : at least one request is set
// ----------------------------------------------------------------------------
module nx_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [IDX_W-1:0] win_idx,
  output logic [N-1:0]     win_onehot,
  output logic             win_valid
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;

  // Walk the requests starting at the pointer; the modulo keeps the wrap
  // correct for channel counts that are not a power of two.
  always_comb begin
    win_idx    = '0;
    win_onehot = '0;
    win_valid  = 1'b0;
    cand       = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % N);
      if (!win_valid && req[cand]) begin
        win_valid        = 1'b1;
        win_idx          = cand;
        win_onehot[cand] = 1'b1;
      end
    end
  end

  // Pointer register: rotate just past whoever was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (int'(win_idx) == N - 1) ? '0 : win_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/nx_ctrl_fabric.sv
// ----------------------------------------------------------------------------
// nx_ctrl_fabric
// Fans one host control stream out to CHANNELS instances (unicast by target
// or broadcast), merges their multi-beat response packets back to the host
// round-robin without interleaving, and aggregates per-instance status.
// Ports:
//   i_clk, i_rst                : clock, asynchronous active-low reset
//   i_ctrl_in_*/o_ctrl_in_ready : host request stream (data, target, bcast)
//   o_chan_in_*/i_chan_in_ready : per-channel request streams
//   i_chan_out_*/o_chan_out_ready : per-channel response streams
//   o_ctrl_out_*/i_ctrl_out_ready : merged host response stream
//   i_chan_active/idle/trigger  : per-instance status
//   o_status_active/idle/trigger: registered aggregate status
//   o_err_target                : pulse after a unicast to a missing channel
// ----------------------------------------------------------------------------
module nx_ctrl_fabric
  import nx_ctrl_fabric_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int REQ_W    = 32,
  parameter int RSP_W    = 32,
  parameter int TGT_W    = $clog2(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [REQ_W-1:0]          i_ctrl_in_data,
  input  logic [TGT_W-1:0]          i_ctrl_in_target,
  input  logic                      i_ctrl_in_bcast,
  input  logic                      i_ctrl_in_valid,
  output logic                      o_ctrl_in_ready,
  output logic [CHANNELS*REQ_W-1:0] o_chan_in_data,
  output logic [CHANNELS-1:0]       o_chan_in_valid,
  input  logic [CHANNELS-1:0]       i_chan_in_ready,
  input  logic [CHANNELS*RSP_W-1:0] i_chan_out_data,
  input  logic [CHANNELS-1:0]       i_chan_out_last,
  input  logic [CHANNELS-1:0]       i_chan_out_valid,
  output logic [CHANNELS-1:0]       o_chan_out_ready,
  output logic [RSP_W-1:0]          o_ctrl_out_data,
  output logic                      o_ctrl_out_last,
  output logic                      o_ctrl_out_valid,
  input  logic                      i_ctrl_out_ready,
  input  logic [CHANNELS-1:0]       i_chan_active,
  input  logic [CHANNELS-1:0]       i_chan_idle,
  input  logic [CHANNELS-1:0]       i_chan_trigger,
  output logic                      o_status_active,
  output logic                      o_status_idle,
  output logic                      o_status_trigger,
  output logic                      o_err_target
);

  // Inbound state
  logic [REQ_W-1:0]    req_q;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic                in_accept, tgt_bad;

  // Outbound state
  fabric_state_t       state_q, state_d;
  logic [TGT_W-1:0]    grant_q, grant_d;
  logic [CHANNELS-1:0] grant_oh, arb_req, win_oh;
  logic [TGT_W-1:0]    win_idx;
  logic                win_valid, free, out_xfer, beat_last;
  logic [RSP_W-1:0]    beat_data;
  logic [RSP_W-1:0]    rsp_beat [CHANNELS];

  // ---------------- Inbound fan-out ----------------

  // Ready whenever every still-pending channel takes its copy this cycle,
  // so a new request can follow the previous one back-to-back. The reset
  // term keeps the handshake outputs at 0 while the fabric is held in reset.
  assign o_ctrl_in_ready = i_rst & ~|(pend_q & ~i_chan_in_ready);
  assign in_accept       = i_ctrl_in_valid & o_ctrl_in_ready;
  assign tgt_bad         = !i_ctrl_in_bcast && (int'(i_ctrl_in_target) >= CHANNELS);
  assign o_chan_in_valid = pend_q;
  assign o_chan_in_data  = {CHANNELS{req_q}};

  // Next pending mask: drop bits that handed off, and let a fresh accept
  // overwrite the mask outright.
  always_comb begin
    pend_d = pend_q & ~i_chan_in_ready;
    if (in_accept) begin
      if (i_ctrl_in_bcast) begin
        pend_d = '1;
      end else if (tgt_bad) begin
        pend_d = '0;
      end else begin
        pend_d = CHANNELS'(1) << i_ctrl_in_target;
      end
    end
  end

  // Request hold, pending mask and the bad-target error pulse.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      req_q        <= '0;
      pend_q       <= '0;
      o_err_target <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      o_err_target <= in_accept & tgt_bad;
      if (in_accept) begin
        req_q <= i_ctrl_in_data;
      end
    end
  end

  // ---------------- Outbound merge ----------------

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign rsp_beat[g] = i_chan_out_data[g*RSP_W +: RSP_W];
  end

  assign free     = ~o_ctrl_out_valid | i_ctrl_out_ready;
  assign grant_oh = CHANNELS'(1) << grant_q;

  // While locked only the granted channel is offered to the arbiter, so the
  // arbiter's winner is always the channel actually being served and its
  // pointer advance lands on grant+1 at the end of the packet.
  assign arb_req = (state_q == LOCKED) ? (i_chan_out_valid & grant_oh) : i_chan_out_valid;

  nx_rr_arbiter #(
    .N     (CHANNELS),
    .IDX_W (TGT_W)
  ) u_arb (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .req        (arb_req),
    .advance    (out_xfer & beat_last),
    .win_idx    (win_idx),
    .win_onehot (win_oh),
    .win_valid  (win_valid)
  );

  assign o_chan_out_ready = {CHANNELS{i_rst & free}} &
                            ((state_q == LOCKED) ? grant_oh : win_oh);
  assign out_xfer  = win_valid & free;
  assign beat_last = i_chan_out_last[win_idx];
  assign beat_data = rsp_beat[win_idx];

  // Lock onto a channel after a non-final beat; release on its last beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ARB: begin
        if (out_xfer && !beat_last) begin
          state_d = LOCKED;
          grant_d = win_idx;
        end
      end
      LOCKED: begin
        if (out_xfer && beat_last) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // FSM registers and the host-side output slice. The slice only moves
  // when it is free, which holds data stable under host backpressure.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q          <= ARB;
      grant_q          <= '0;
      o_ctrl_out_data  <= '0;
      o_ctrl_out_last  <= 1'b0;
      o_ctrl_out_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (free) begin
        o_ctrl_out_valid <= out_xfer;
        if (out_xfer) begin
          o_ctrl_out_data <= beat_data;
          o_ctrl_out_last <= beat_last;
        end
      end
    end
  end

  // ---------------- Status aggregation ----------------

  // One-cycle registered reduction of the per-instance status bits.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_status_active  <= 1'b0;
      o_status_idle    <= 1'b0;
      o_status_trigger <= 1'b0;
    end else begin
      o_status_active  <= |i_chan_active;
      o_status_idle    <= &i_chan_idle;
      o_status_trigger <= |i_chan_trigger;
    end
  end

endmodule

// File: tb/tb_nx_ctrl_fabric.sv
// ----------------------------------------------------------------------------
// tb_nx_ctrl_fabric
// Directed bench for nx_ctrl_fabric: a 4-channel instance for the main
// traffic scenarios and a 3-channel instance for out-of-range targets.
// ----------------------------------------------------------------------------
module tb_nx_ctrl_fabric;

  logic clk;
  logic rst_n;

  // 4-channel instance
  logic [31:0]  ctrl_in_data;
  logic [1:0]   ctrl_in_target;
  logic         ctrl_in_bcast;
  logic         ctrl_in_valid;
  logic         ctrl_in_ready;
  logic [127:0] chan_in_data;
  logic [3:0]   chan_in_valid;
  logic [3:0]   chan_in_ready;
  logic [127:0] chan_out_data;
  logic [3:0]   chan_out_last;
  logic [3:0]   chan_out_valid;
  logic [3:0]   chan_out_ready;
  logic [31:0]  ctrl_out_data;
  logic         ctrl_out_last;
  logic         ctrl_out_valid;
  logic         ctrl_out_ready;
  logic [3:0]   chan_active, chan_idle, chan_trigger;
  logic         status_active, status_idle, status_trigger;
  logic         err_target;

  // 3-channel instance
  logic [31:0]  c3_in_data;
  logic [1:0]   c3_in_target;
  logic         c3_in_valid;
  logic         c3_in_ready;
  logic [95:0]  c3_chan_in_data;
  logic [2:0]   c3_chan_in_valid;
  logic [2:0]   c3_chan_in_ready;
  logic [2:0]   c3_chan_out_ready;
  logic [31:0]  c3_out_data;
  logic         c3_out_last;
  logic         c3_out_valid;
  logic         c3_status_active, c3_status_idle, c3_status_trigger;
  logic         c3_err_target;

  int checkCount = 0;
  int passCount  = 0;
  int hs_count [4];
  int hs_base  [4];

  nx_ctrl_fabric #(.CHANNELS(4), .REQ_W(32), .RSP_W(32)) dut (
    .i_clk            (clk),
    .i_rst            (rst_n),
    .i_ctrl_in_data   (ctrl_in_data),
    .i_ctrl_in_target (ctrl_in_target),
    .i_ctrl_in_bcast  (ctrl_in_bcast),
    .i_ctrl_in_valid  (ctrl_in_valid),
    .o_ctrl_in_ready  (ctrl_in_ready),
    .o_chan_in_data   (chan_in_data),
    .o_chan_in_valid  (chan_in_valid),
    .i_chan_in_ready  (chan_in_ready),
    .i_chan_out_data  (chan_out_data),
    .i_chan_out_last  (chan_out_last),
    .i_chan_out_valid (chan_out_valid),
    .o_chan_out_ready (chan_out_ready),
    .o_ctrl_out_data  (ctrl_out_data),
    .o_ctrl_out_last  (ctrl_out_last),
    .o_ctrl_out_valid (ctrl_out_valid),
    .i_ctrl_out_ready (ctrl_out_ready),
    .i_chan_active    (chan_active),
    .i_chan_idle      (chan_idle),
    .i_chan_trigger   (chan_trigger),
    .o_status_active  (status_active),
    .o_status_idle    (status_idle),
    .o_status_trigger (status_trigger),
    .o_err_target     (err_target)
  );

  nx_ctrl_fabric #(.CHANNELS(3), .REQ_W(32), .RSP_W(32)) dut3 (
    .i_clk            (clk),
    .i_rst            (rst_n),
    .i_ctrl_in_data   (c3_in_data),
    .i_ctrl_in_target (c3_in_target),
    .i_ctrl_in_bcast  (1'b0),
    .i_ctrl_in_valid  (c3_in_valid),
    .o_ctrl_in_ready  (c3_in_ready),
    .o_chan_in_data   (c3_chan_in_data),
    .o_chan_in_valid  (c3_chan_in_valid),
    .i_chan_in_ready  (c3_chan_in_ready),
    .i_chan_out_data  (96'd0),
    .i_chan_out_last  (3'd0),
    .i_chan_out_valid (3'd0),
    .o_chan_out_ready (c3_chan_out_ready),
    .o_ctrl_out_data  (c3_out_data),
    .o_ctrl_out_last  (c3_out_last),
    .o_ctrl_out_valid (c3_out_valid),
    .i_ctrl_out_ready (1'b1),
    .i_chan_active    (3'd0),
    .i_chan_idle      (3'd0),
    .i_chan_trigger   (3'd0),
    .o_status_active  (c3_status_active),
    .o_status_idle    (c3_status_idle),
    .o_status_trigger (c3_status_trigger),
    .o_err_target     (c3_err_target)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count per-channel request handshakes on the 4-channel instance
  initial for (int i = 0; i < 4; i++) hs_count[i] = 0;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (chan_in_valid[i] && chan_in_ready[i]) hs_count[i] <= hs_count[i] + 1;
    end
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic bcast,
                               input logic [1:0] target, input logic [31:0] data);
    ctrl_in_valid  = valid;
    ctrl_in_bcast  = bcast;
    ctrl_in_target = target;
    ctrl_in_data   = data;
  endtask

  task automatic snapHandshakes();
    for (int i = 0; i < 4; i++) hs_base[i] = hs_count[i];
  endtask

  initial begin
    // ---------------- Reset ----------------
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h1111_1111);
    chan_in_ready  = 4'hF;
    chan_out_data  = '0;
    chan_out_last  = 4'hF;
    chan_out_valid = 4'b0001;
    ctrl_out_ready = 1'b1;
    chan_active    = 4'hF;
    chan_idle      = 4'hF;
    chan_trigger   = 4'hF;
    c3_in_data     = '0;
    c3_in_target   = '0;
    c3_in_valid    = 1'b0;
    c3_chan_in_ready = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready",  32'(ctrl_in_ready), 32'd0);
    checkOutput("rst_chan_valid", 32'(chan_in_valid), 32'd0);
    checkOutput("rst_out_ready", 32'(chan_out_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(ctrl_out_valid), 32'd0);
    checkOutput("rst_status", 32'({status_active, status_idle, status_trigger}), 32'd0);
    checkOutput("rst_err", 32'(err_target), 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'd0);
    chan_out_valid = 4'b0000;

    // ---------------- Status (1-cycle latency) ----------------
    @(posedge clk); #1;
    chan_active = 4'b0000; chan_idle = 4'b1110; chan_trigger = 4'b0000;
    @(negedge clk);
    checkOutput("status_all_set", 32'({status_active, status_idle, status_trigger}), 32'b111);
    @(posedge clk); #1;
    chan_active = 4'b0010; chan_idle = 4'b1111; chan_trigger = 4'b0100;
    @(negedge clk);
    checkOutput("status_all_clr", 32'({status_active, status_idle, status_trigger}), 32'b000);
    @(posedge clk); #1;
    chan_active = '0; chan_idle = '0; chan_trigger = '0;
    @(negedge clk);
    checkOutput("status_mix", 32'({status_active, status_idle, status_trigger}), 32'b111);

    // ---------------- Unicast back-to-back ----------------
    snapHandshakes();
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 2'd2, 32'hA5A5_0001);
    @(negedge clk);
    checkOutput("uc_ready0", 32'(ctrl_in_ready), 32'd1);
    checkOutput("uc_valid0", 32'(chan_in_valid), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0000_BEEF);
    @(negedge clk);
    checkOutput("uc_valid1", 32'(chan_in_valid), 32'b0100);
    checkOutput("uc_data1", chan_in_data[2*32 +: 32], 32'hA5A5_0001);
    checkOutput("uc_ready1", 32'(ctrl_in_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'd0);
    @(negedge clk);
    checkOutput("uc_valid2", 32'(chan_in_valid), 32'b0001);
    checkOutput("uc_data2", chan_in_data[0 +: 32], 32'h0000_BEEF);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("uc_valid3", 32'(chan_in_valid), 32'd0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("uc_hs%0d", i), 32'(hs_count[i] - hs_base[i]),
                  (i == 0 || i == 2) ? 32'd1 : 32'd0);

    // ---------------- Broadcast with skewed ready ----------------
    snapHandshakes();
    @(posedge clk); #1;
    chan_in_ready = 4'b1101;
    applyStimulus(1'b1, 1'b1, 2'd0, 32'h1234_5678);
    @(negedge clk);
    checkOutput("bc_ready_a", 32'(ctrl_in_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 2'd3, 32'hCAFE_0003);
    @(negedge clk);
    checkOutput("bc_valid_b", 32'(chan_in_valid), 32'hF);
    checkOutput("bc_data_b", chan_in_data[1*32 +: 32], 32'h1234_5678);
    checkOutput("bc_ready_b", 32'(ctrl_in_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("bc_valid_wait", 32'(chan_in_valid), 32'b0010);
      checkOutput("bc_ready_wait", 32'(ctrl_in_ready), 32'd0);
    end
    @(posedge clk); #1;
    chan_in_ready = 4'hF;
    @(negedge clk);
    checkOutput("bc_ready_e", 32'(ctrl_in_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'd0);
    @(negedge clk);
    checkOutput("bc_next_valid", 32'(chan_in_valid), 32'b1000);
    checkOutput("bc_next_data", chan_in_data[3*32 +: 32], 32'hCAFE_0003);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bc_done", 32'(chan_in_valid), 32'd0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("bc_hs%0d", i), 32'(hs_count[i] - hs_base[i]),
                  (i == 3) ? 32'd2 : 32'd1);

    // ---------------- Bad target on the 3-channel instance ----------------
    @(posedge clk); #1;
    c3_in_valid = 1'b1; c3_in_target = 2'd3; c3_in_data = 32'hBAD0_0003;
    @(negedge clk);
    checkOutput("bt_ready", 32'(c3_in_ready), 32'd1);
    checkOutput("bt_err_pre", 32'(c3_err_target), 32'd0);
    @(posedge clk); #1;
    c3_in_target = 2'd2; c3_in_data = 32'h0000_3002;
    @(negedge clk);
    checkOutput("bt_no_valid", 32'(c3_chan_in_valid), 32'd0);
    checkOutput("bt_err_pulse", 32'(c3_err_target), 32'd1);
    @(posedge clk); #1;
    c3_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bt_err_clear", 32'(c3_err_target), 32'd0);
    checkOutput("bt_good_valid", 32'(c3_chan_in_valid), 32'b100);
    checkOutput("bt_good_data", c3_chan_in_data[2*32 +: 32], 32'h0000_3002);
    checkOutput("bt_main_err", 32'(err_target), 32'd0);

    // ---------------- Round-robin fairness ----------------
    @(posedge clk); #1;
    chan_out_valid = 4'hF;
    chan_out_last  = 4'hF;
    for (int i = 0; i < 4; i++) chan_out_data[i*32 +: 32] = 32'hD000_0000 + 32'(i);
    ctrl_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("rr_ready", 32'(chan_out_ready), 32'd1 << (k % 4));
      if (k > 0) begin
        checkOutput("rr_data", ctrl_out_data, 32'hD000_0000 + 32'((k - 1) % 4));
        checkOutput("rr_valid_last", 32'({ctrl_out_valid, ctrl_out_last}), 32'b11);
      end
      @(posedge clk); #1;
    end
    chan_out_valid = 4'h0;
    @(negedge clk);
    checkOutput("rr_tail", ctrl_out_data, 32'hD000_0001);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rr_drain", 32'(ctrl_out_valid), 32'd0);

    // ---------------- Packet locking (pointer now at 2) ----------------
    @(posedge clk); #1;
    chan_out_valid = 4'b0010;
    chan_out_last  = 4'b0000;
    chan_out_data[1*32 +: 32] = 32'hB100_0000;
    @(negedge clk);
    checkOutput("lk_ready0", 32'(chan_out_ready), 32'b0010);
    @(posedge clk); #1;
    chan_out_valid = 4'b0011;
    chan_out_last  = 4'b0001;
    chan_out_data[0 +: 32]    = 32'hA000_0000;
    chan_out_data[1*32 +: 32] = 32'hB100_0001;
    @(negedge clk);
    checkOutput("lk_ready1", 32'(chan_out_ready), 32'b0010);
    checkOutput("lk_beat0", ctrl_out_data, 32'hB100_0000);
    checkOutput("lk_last0", 32'(ctrl_out_last), 32'd0);
    @(posedge clk); #1;
    chan_out_data[1*32 +: 32] = 32'hB100_0002;
    @(negedge clk);
    checkOutput("lk_ready2", 32'(chan_out_ready), 32'b0010);
    checkOutput("lk_beat1", ctrl_out_data, 32'hB100_0001);
    @(posedge clk); #1;
    chan_out_valid = 4'b0111;
    chan_out_last  = 4'b0111;
    chan_out_data[1*32 +: 32] = 32'hB100_0003;
    chan_out_data[2*32 +: 32] = 32'hC200_0000;
    @(negedge clk);
    checkOutput("lk_ready3", 32'(chan_out_ready), 32'b0010);
    checkOutput("lk_beat2", ctrl_out_data, 32'hB100_0002);
    @(posedge clk); #1;
    chan_out_valid = 4'b0101;
    @(negedge clk);
    checkOutput("lk_beat3", ctrl_out_data, 32'hB100_0003);
    checkOutput("lk_last3", 32'(ctrl_out_last), 32'd1);
    checkOutput("lk_next_ch2", 32'(chan_out_ready), 32'b0100);
    @(posedge clk); #1;
    chan_out_valid = 4'b0001;
    @(negedge clk);
    checkOutput("lk_ch2_data", ctrl_out_data, 32'hC200_0000);
    checkOutput("lk_then_ch0", 32'(chan_out_ready), 32'b0001);
    @(posedge clk); #1;
    chan_out_valid = 4'b0000;
    @(negedge clk);
    checkOutput("lk_ch0_data", ctrl_out_data, 32'hA000_0000);

    // ---------------- Host backpressure, then reset (pointer at 1) ----------------
    @(posedge clk); #1;
    chan_out_valid = 4'b1000;
    chan_out_last  = 4'b0000;
    chan_out_data[3*32 +: 32] = 32'hE300_0000;
    @(negedge clk);
    checkOutput("bp_ready0", 32'(chan_out_ready), 32'b1000);
    @(posedge clk); #1;
    chan_out_data[3*32 +: 32] = 32'hE300_0001;
    ctrl_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_hold_data", ctrl_out_data, 32'hE300_0000);
      checkOutput("bp_hold_valid", 32'(ctrl_out_valid), 32'd1);
      checkOutput("bp_no_ready", 32'(chan_out_ready), 32'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h5555_5555);
    @(negedge clk);
    checkOutput("bp_rst_valid", 32'(ctrl_out_valid), 32'd0);
    checkOutput("bp_rst_data", ctrl_out_data, 32'd0);
    checkOutput("bp_rst_chready", 32'(chan_out_ready), 32'd0);
    checkOutput("bp_rst_inready", 32'(ctrl_in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'd0);
    ctrl_out_ready = 1'b1;
    chan_out_valid = 4'b1001;
    chan_out_last  = 4'b1001;
    chan_out_data[0 +: 32] = 32'hF000_0000;
    @(negedge clk);
    checkOutput("bp_ptr_zero", 32'(chan_out_ready), 32'b0001);
    @(posedge clk); #1;
    chan_out_valid = 4'b0000;
    @(negedge clk);
    checkOutput("bp_after_data", ctrl_out_data, 32'hF000_0000);
    checkOutput("bp_after_last", 32'(ctrl_out_last), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/nx_ctrl_fabric.md
Name: nx_ctrl_fabric

Overview:
- Multi-instance successor to the single-mesh top-level control path.
- Fans one host control stream out to CHANNELS independent control/mesh instances, by target index or broadcast.
- Merges their multi-beat response streams back to the host with round-robin arbitration; packets are never interleaved.
- Aggregates per-instance status into the host-visible status outputs.

Parameters:
- CHANNELS, 4: number of downstream instances; legal range is 2 or more.
- REQ_W, 32: width of a control request beat.
- RSP_W, 32: width of a control response beat.
- TGT_W, $clog2(CHANNELS): target index width (derived; never overridden).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-low
- i_ctrl_in_data  in  REQ_W  host request beat
- i_ctrl_in_target  in  TGT_W  destination channel
- i_ctrl_in_bcast  in  1  deliver to all channels; target ignored
- i_ctrl_in_valid  in  1  host request valid
- o_ctrl_in_ready  out  1  host request ready
- o_chan_in_data  out  CHANNELS*REQ_W  per-channel request; all slices carry the same held value
- o_chan_in_valid  out  CHANNELS  per-channel request valid
- i_chan_in_ready  in  CHANNELS  per-channel request ready
- i_chan_out_data  in  CHANNELS*RSP_W  per-channel response beat
- i_chan_out_last  in  CHANNELS  final beat of a response packet
- i_chan_out_valid  in  CHANNELS  per-channel response valid
- o_chan_out_ready  out  CHANNELS  per-channel response ready
- o_ctrl_out_data  out  RSP_W  merged response beat
- o_ctrl_out_last  out  1  merged last flag
- o_ctrl_out_valid  out  1  merged valid
- i_ctrl_out_ready  in  1  host ready
- i_chan_active, i_chan_idle, i_chan_trigger  in  CHANNELS each  per-instance status
- o_status_active, o_status_idle, o_status_trigger  out  1 each  aggregated status
- o_err_target  out  1  one-cycle pulse when a unicast target is at or above CHANNELS

Behaviour:
- Reset: while i_rst is low, all registers and outputs are 0. This covers pending mask, request hold, output slice, FSM (ARB), RR pointer (0), status and o_err_target. Assertion mid-operation discards any held request and any partial packet. Deassertion is synchronised externally.
- Inbound datapath:
  - Holds one request register req_q and a pending mask pend[CHANNELS].
  - o_chan_in_valid equals pend; every slice of o_chan_in_data equals req_q.
  - pend[i] clears on o_chan_in_valid[i] & i_chan_in_ready[i].
  - o_ctrl_in_ready = ~|(pend & ~i_chan_in_ready), i.e. ready when nothing is pending or every pending bit completes this cycle. This gives back-to-back throughput.
- Inbound accept (valid & ready):
  - req_q loads the request data.
  - Broadcast: pend = all ones.
  - Valid unicast target: pend = onehot(target).
  - Target at or above CHANNELS: pend = 0, request dropped, o_err_target pulses the next cycle.
- Inbound latency and ordering: a request is visible downstream one cycle after host accept. A broadcast completes only when every channel has taken it; channels may accept on different cycles, and a channel that has accepted is not re-presented.
- Outbound output slice: holds o_ctrl_out_data/last/valid; free = ~o_ctrl_out_valid | i_ctrl_out_ready.
- Outbound FSM, ARB state:
  - Winner = first valid channel searching from ptr upward, wrapping modulo CHANNELS.
  - o_chan_out_ready[winner] = free; all other ready bits are 0.
  - On transfer the slice loads the beat.
  - If last: stay in ARB, ptr = winner+1 mod CHANNELS.
  - Otherwise: grant = winner, go to LOCKED.
- Outbound FSM, LOCKED state:
  - Only channel grant sees ready = free; other valids wait.
  - A transfer with last returns to ARB with ptr = grant+1 mod CHANNELS.
- Outbound latency: channel to host is 1 cycle; a full rate of 1 beat/cycle is sustained while the host holds ready.
- No valid in ARB: slice drains; ptr unchanged.
- Status: registered, 1-cycle latency.
  - o_status_active = OR of i_chan_active.
  - o_status_idle = AND of i_chan_idle.
  - o_status_trigger = OR of i_chan_trigger.
- Simultaneous events: an inbound accept and a clear of the last pend bit in the same cycle load the new mask; the new load takes precedence.

Decomposition:
- NXConstants gains fabric_state_t (ARB, LOCKED).
- Sub-module nx_rr_arbiter: parameter N; request vector, advance strobe, winner index/onehot, rotating pointer.
- The locking FSM and all datapaths stay in nx_ctrl_fabric.

Test Plan:
- Unicast: target=2 with data 0xA5A5_0001 while all channels are ready. The request appears only on channel 2, one cycle after accept; pend returns to 0; the next request is accepted the same cycle.
- Broadcast skew: bcast with data 0x1234_5678; channel 1 ready lags channel 0 by 3 cycles. o_ctrl_in_ready stays low until the last channel accepts, and each channel receives exactly one beat.
- Bad target: CHANNELS=3, target=3. Request is dropped, no channel valid asserts, o_err_target is high for exactly one cycle.
- Fairness: all 4 channels present single-beat packets continuously. Grant order is 0,1,2,3,0,… with 1 beat/cycle at host ready=1.
- Locking: channel 1 sends a 4-beat packet while channel 0 asserts valid mid-packet. The host sees 4 contiguous channel-1 beats with last on beat 4, then channel 2 (or the next valid at or above ptr) is served before channel 0.
- Host backpressure and reset: hold i_ctrl_out_ready=0 for 5 cycles mid-packet, then drive i_rst low. Data is stable during the stall; on reset all outputs are 0 and the FSM is in ARB with ptr=0.
